// File: rtl/riscv_regfile_mp.sv
// Multi-port RV32 integer register file with a post-reset clear sweep (no per-entry reset on storage).
// Optional same-cycle write-to-read forwarding when RISCV_REGFILE_BYPASS_EN is defined.
module riscv_regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
) (
    input  logic                     i_regfile_clk,
    input  logic                     i_regfile_rst,
    input  logic [NUM_RD*5-1:0]      i_regfile_rd_addr,
    output logic [NUM_RD*XLEN-1:0]   o_regfile_rd_data,
    input  logic [NUM_WR-1:0]        i_regfile_wen,
    input  logic [NUM_WR*5-1:0]      i_regfile_wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   i_regfile_wr_data,
    output logic                     o_regfile_ready
);
    localparam int AW = $clog2(NREG);

    typedef enum logic {CLEAR, READY} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [XLEN-1:0] mem_q [NREG];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == CLEAR) begin
            // Sweep exits on the last entry, so the counter never wraps.
            if (clr_cnt_q == AW'(NREG - 1)) state_d = READY;
            else                            clr_cnt_d = clr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_regfile_clk) begin
        if (i_regfile_rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage carries no reset so it can map onto RAM; ascending loop lets the higher port win.
    always_ff @(posedge i_regfile_clk) begin
        if (!i_regfile_rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (i_regfile_wen[w] && i_regfile_wr_addr[5*w +: 5] != 5'd0 &&
                        32'(i_regfile_wr_addr[5*w +: 5]) < NREG)
                        mem_q[i_regfile_wr_addr[5*w +: AW]] <= i_regfile_wr_data[XLEN*w +: XLEN];
                end
            end
        end
    end

    assign o_regfile_ready = (state_q == READY);

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [4:0]      ra;
        logic [XLEN-1:0] rdat;
        assign ra = i_regfile_rd_addr[5*k +: 5];
        always_comb begin
            rdat = '0;
            if (state_q == READY && ra != 5'd0 && 32'(ra) < NREG) begin
                rdat = mem_q[ra[AW-1:0]];
`ifdef RISCV_REGFILE_BYPASS_EN
                for (int w = 0; w < NUM_WR; w++) begin
                    if (i_regfile_wen[w] && i_regfile_wr_addr[5*w +: 5] == ra)
                        rdat = i_regfile_wr_data[XLEN*w +: XLEN];
                end
`endif
            end
        end
        assign o_regfile_rd_data[XLEN*k +: XLEN] = rdat;
    end
endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Directed bench: a 32-entry and a 16-entry register file driven from the same stimulus.
module tb_riscv_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [1:0]  wen;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [63:0] rd32, rd16;
    logic        rdy32, rdy16;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    riscv_regfile_mp #(.XLEN(32), .NREG(32), .NUM_RD(2), .NUM_WR(2)) u_dut32 (
        .i_regfile_clk(clk), .i_regfile_rst(rst),
        .i_regfile_rd_addr(rd_addr), .o_regfile_rd_data(rd32),
        .i_regfile_wen(wen), .i_regfile_wr_addr(wr_addr), .i_regfile_wr_data(wr_data),
        .o_regfile_ready(rdy32)
    );

    riscv_regfile_mp #(.XLEN(32), .NREG(16), .NUM_RD(2), .NUM_WR(2)) u_dut16 (
        .i_regfile_clk(clk), .i_regfile_rst(rst),
        .i_regfile_rd_addr(rd_addr), .o_regfile_rd_data(rd16),
        .i_regfile_wen(wen), .i_regfile_wr_addr(wr_addr), .i_regfile_wr_data(wr_data),
        .o_regfile_ready(rdy16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and checks happen well away from it.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [1:0] en, input logic [4:0] a1, input logic [4:0] a0,
                      input logic [31:0] d1, input logic [31:0] d0);
        wen     = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
        rd_addr = {a1, a0};
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        rst = 1'b0;
        chk("reset_ready32", {31'b0, rdy32}, 32'd0);
        chk("reset_ready16", {31'b0, rdy16}, 32'd0);

        // Sweep, with a write attempt to x5 held while both files are still clearing.
        wr(2'b01, 5'd0, 5'd5, 32'h0, 32'hDEAD_BEEF);
        rd(5'd7, 5'd5);
        chk("clear_rd0", rd32[31:0], 32'd0);
        chk("clear_rd1", rd32[63:32], 32'd0);
        for (int i = 1; i <= 31; i++) begin
            if (i == 15) wen = 2'b00;
            step();
            chk($sformatf("sweep32_e%0d", i), {31'b0, rdy32}, (i >= 31) ? 32'd1 : 32'd0);
            if (i == 14 || i == 15)
                chk($sformatf("sweep16_e%0d", i), {31'b0, rdy16}, (i >= 15) ? 32'd1 : 32'd0);
        end
        rd(5'd5, 5'd5);
        chk("clr_wr_x5_32", rd32[31:0], 32'd0);
        chk("clr_wr_x5_16", rd16[31:0], 32'd0);
        rd(5'd31, 5'd1);
        chk("swept_x1", rd32[31:0], 32'd0);
        chk("swept_x31", rd32[63:32], 32'd0);

        // Same-address collision: port 1 wins.
        wr(2'b11, 5'd7, 5'd7, 32'h2222, 32'h1111);
        step();
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        rd(5'd7, 5'd7);
        chk("coll_x7_32", rd32[31:0], 32'h2222);
        chk("coll_x7_16", rd16[63:32], 32'h2222);

        // Distinct addresses both commit.
        wr(2'b11, 5'd4, 5'd3, 32'd2, 32'd1);
        step();
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        rd(5'd4, 5'd3);
        chk("dual_x3", rd32[31:0], 32'd1);
        chk("dual_x4", rd32[63:32], 32'd2);
        chk("dual_x3_16", rd16[31:0], 32'd1);

        // x0 stays zero; x20 is out of range only for the 16-entry file.
        wr(2'b11, 5'd20, 5'd0, 32'h55, 32'hFFFF_FFFF);
        step();
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        rd(5'd20, 5'd0);
        chk("x0_32", rd32[31:0], 32'd0);
        chk("x20_32", rd32[63:32], 32'h55);
        chk("x0_16", rd16[31:0], 32'd0);
        chk("x20_16", rd16[63:32], 32'd0);
        wr(2'b01, 5'd0, 5'd15, 32'h0, 32'hCAFE);
        step();
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        rd(5'd0, 5'd15);
        chk("x15_16", rd16[31:0], 32'hCAFE);
        chk("x15_32", rd32[31:0], 32'hCAFE);

        // Read-during-write on x9.
        wr(2'b01, 5'd0, 5'd9, 32'h0, 32'h1234);
        step();
        wr(2'b01, 5'd0, 5'd9, 32'h0, 32'hA5A5);
        rd(5'd0, 5'd9);
`ifdef RISCV_REGFILE_BYPASS_EN
        chk("rdw_same_cyc", rd32[31:0], 32'hA5A5);
`else
        chk("rdw_same_cyc", rd32[31:0], 32'h1234);
`endif
        step();
        wr(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        rd(5'd0, 5'd9);
        chk("rdw_next_cyc", rd32[31:0], 32'hA5A5);

        // Reset mid-sweep restarts it; old contents are wiped.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 1; i <= 9; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midsweep_rdy", {31'b0, rdy32}, 32'd0);
        for (int i = 1; i <= 31; i++) begin
            step();
            if (i == 30 || i == 31)
                chk($sformatf("resweep_e%0d", i), {31'b0, rdy32}, (i >= 31) ? 32'd1 : 32'd0);
        end
        rd(5'd9, 5'd7);
        chk("wiped_x7", rd32[31:0], 32'd0);
        chk("wiped_x9", rd32[63:32], 32'd0);
        rd(5'd15, 5'd20);
        chk("wiped_x20", rd32[31:0], 32'd0);
        chk("wiped_x15_16", rd16[63:32], 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
